// File: rtl/controle_preparo_pkg.sv
// Shared definitions for the brew controller: state encoding, error codes and
// default watchdog limits (reused by the display and the top level).
package controle_preparo_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    VERIFICA = 3'd1,
    AQUECE   = 3'd2,
    ABRE     = 3'd3,
    DISPENSA = 3'd4,
    CONCLUI  = 3'd5,
    ERRO     = 3'd6
  } estado_t;

  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_SEM_AGUA    = 2'b01;
  localparam logic [1:0] ERR_TEMPO_AQUEC = 2'b10;
  localparam logic [1:0] ERR_TEMPO_VALV  = 2'b11;

  // 30 s and 65 s at 50 MHz
  localparam logic [31:0] TIMEOUT_AQUEC_PADRAO = 32'd1500000000;
  localparam logic [31:0] TIMEOUT_VALV_PADRAO  = 32'd3250000000;

endpackage

// File: rtl/controle_preparo_temporizador.sv
// Watchdog counter: synchronous clear, count enable, and a registered flag
// that is high while the count sits at limite-1.
module temporizador_preparo #(
  parameter int unsigned N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         limpa,
  input  logic         conta,
  input  logic [N-1:0] limite,
  output logic         fim
);

  localparam logic [N-1:0] UM = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] contagem;
  logic [N-1:0] cont_nxt;

  always_comb begin
    cont_nxt = contagem;
    if (limpa)
      cont_nxt = '0;
    else if (conta)
      cont_nxt = contagem + UM;
  end

  // fim is evaluated on the next count so it lines up with the count itself
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
      fim      <= 1'b0;
    end else begin
      contagem <= cont_nxt;
      fim      <= (cont_nxt == (limite - UM));
    end
  end

endmodule

// File: rtl/controle_preparo.sv
// Brew-sequence controller: level check, heating, valve command and dispense
// supervision with watchdogs, error reporting and a saturating cup counter.
module controle_preparo
  import controle_preparo_pkg::*;
#(
  parameter int unsigned   N             = 32,
  parameter logic [N-1:0]  TIMEOUT_AQUEC = N'(TIMEOUT_AQUEC_PADRAO),
  parameter logic [N-1:0]  TIMEOUT_VALV  = N'(TIMEOUT_VALV_PADRAO)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       cancelar,
  input  logic       nivel_ok,
  input  logic       agua_quente,
  input  logic       fim_valvula,
  output logic       liga_aquecedor,
  output logic       liga_valvula,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro,
  output logic [1:0] codigo_erro,
  output logic [7:0] cafes_servidos,
  output logic [2:0] db_estado
);

  estado_t      estado, prox;
  logic         tempo_fim;
  logic         limpa, conta;
  logic [N-1:0] limite;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      estado <= OCIOSO;
    else
      estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:   if (iniciar) prox = VERIFICA;
      VERIFICA: prox = nivel_ok ? AQUECE : ERRO;
      AQUECE: begin
        if (cancelar)         prox = OCIOSO;
        else if (agua_quente) prox = ABRE;
        else if (tempo_fim)   prox = ERRO;
      end
      ABRE:     prox = DISPENSA;
      // no cancel here: the valve controller cannot be aborted
      DISPENSA: begin
        if (fim_valvula)    prox = CONCLUI;
        else if (tempo_fim) prox = ERRO;
      end
      CONCLUI:  prox = OCIOSO;
      ERRO:     if (cancelar) prox = OCIOSO;
      default:  prox = OCIOSO;
    endcase
  end

  assign limpa  = (estado == VERIFICA) || (estado == ABRE);
  assign conta  = (estado == AQUECE) || (estado == DISPENSA);
  // limit follows the state being entered so the registered flag is valid on arrival
  assign limite = (prox == DISPENSA) ? TIMEOUT_VALV : TIMEOUT_AQUEC;

  temporizador_preparo #(.N(N)) u_temporizador (
    .clock  (clock),
    .reset  (reset),
    .limpa  (limpa),
    .conta  (conta),
    .limite (limite),
    .fim    (tempo_fim)
  );

  // outputs registered from the next state, so they align with db_estado
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      liga_aquecedor <= 1'b0;
      liga_valvula   <= 1'b0;
      ocupado        <= 1'b0;
      pronto         <= 1'b0;
      erro           <= 1'b0;
      codigo_erro    <= ERR_NONE;
      cafes_servidos <= 8'd0;
    end else begin
      liga_aquecedor <= (prox == AQUECE) || (prox == ABRE) || (prox == DISPENSA);
      liga_valvula   <= (prox == ABRE);
      ocupado        <= (prox != OCIOSO) && (prox != ERRO);
      pronto         <= (prox == CONCLUI);
      erro           <= (prox == ERRO);
      if (prox == ERRO) begin
        if (estado == VERIFICA)      codigo_erro <= ERR_SEM_AGUA;
        else if (estado == AQUECE)   codigo_erro <= ERR_TEMPO_AQUEC;
        else if (estado == DISPENSA) codigo_erro <= ERR_TEMPO_VALV;
      end else begin
        codigo_erro <= ERR_NONE;
      end
      if ((prox == CONCLUI) && (cafes_servidos != 8'hFF))
        cafes_servidos <= cafes_servidos + 8'd1;
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_controle_preparo.sv
// Bench for controle_preparo: vector table, directed multi-cycle sequences and
// random stimulus checked every cycle against a phase/elapsed-time model.
module tb_controle_preparo;

  localparam int TA = 20;
  localparam int TV = 50;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0, cancelar = 1'b0, nivel_ok = 1'b0;
  logic       agua_quente = 1'b0, fim_valvula = 1'b0;
  logic       liga_aquecedor, liga_valvula, ocupado, pronto, erro;
  logic [1:0] codigo_erro;
  logic [7:0] cafes_servidos;
  logic [2:0] db_estado;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b1;

  always #5 clock = ~clock;

  controle_preparo #(
    .N(32), .TIMEOUT_AQUEC(32'd20), .TIMEOUT_VALV(32'd50)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .cancelar(cancelar),
    .nivel_ok(nivel_ok), .agua_quente(agua_quente), .fim_valvula(fim_valvula),
    .liga_aquecedor(liga_aquecedor), .liga_valvula(liga_valvula), .ocupado(ocupado),
    .pronto(pronto), .erro(erro), .codigo_erro(codigo_erro),
    .cafes_servidos(cafes_servidos), .db_estado(db_estado)
  );

  // {db, heater, valve, busy, done, error, code, cups}
  function automatic logic [17:0] saida_dut();
    return {db_estado, liga_aquecedor, liga_valvula, ocupado, pronto, erro,
            codigo_erro, cafes_servidos};
  endfunction

  // Reference model: phase number plus cycles spent in that phase
  int m_fase = 0, m_n = 0, m_cod = 0, m_cafes = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_fase <= 0; m_n <= 0; m_cod <= 0; m_cafes <= 0;
    end else begin
      int f, c;
      f = m_fase; c = m_cod;
      case (m_fase)
        0: if (iniciar) f = 1;
        1: if (nivel_ok) f = 2; else begin f = 6; c = 1; end
        2: if (cancelar) f = 0;
           else if (agua_quente) f = 3;
           else if (m_n + 1 >= TA) begin f = 6; c = 2; end
        3: f = 4;
        4: if (fim_valvula) f = 5;
           else if (m_n + 1 >= TV) begin f = 6; c = 3; end
        5: f = 0;
        default: if (cancelar) begin f = 0; c = 0; end
      endcase
      m_n    <= (f == m_fase) ? m_n + 1 : 0;
      m_fase <= f;
      m_cod  <= c;
      if (f == 5 && m_cafes < 255) m_cafes <= m_cafes + 1;
    end
  end

  function automatic logic [17:0] saida_modelo();
    logic h, v, o, p, e;
    h = (m_fase >= 2 && m_fase <= 4);
    v = (m_fase == 3);
    o = (m_fase >= 1 && m_fase <= 5);
    p = (m_fase == 5);
    e = (m_fase == 6);
    return {3'(m_fase), h, v, o, p, e, 2'(m_cod), 8'(m_cafes)};
  endfunction

  always @(posedge clock) begin
    #1;
    if (mon_en) begin
      total++;
      if (saida_dut() !== saida_modelo()) begin
        bad++;
        $display("FAIL model t=%0t dut=%h model=%h", $time, saida_dut(), saida_modelo());
      end
    end
  end

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nome, got, exp);
    end
  endtask

  task automatic ciclo(input logic ini, input logic canc, input logic niv,
                       input logic aq, input logic fim);
    @(negedge clock);
    iniciar = ini; cancelar = canc; nivel_ok = niv; agua_quente = aq; fim_valvula = fim;
    @(posedge clock);
    #2;
  endtask

  task automatic aplica_reset();
    @(negedge clock);
    reset = 1'b0;
    iniciar = 0; cancelar = 0; nivel_ok = 0; agua_quente = 0; fim_valvula = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic preparo_rapido();
    ciclo(1, 0, 1, 0, 0);
    ciclo(0, 0, 1, 0, 0);
    ciclo(0, 0, 1, 1, 0);
    ciclo(0, 0, 1, 0, 0);
    ciclo(0, 0, 1, 0, 1);
    ciclo(0, 0, 1, 0, 0);
  endtask

  typedef struct packed {
    logic ini, canc, niv, aq, fim;
    logic [2:0] db;
    logic h, v, o, p, e;
    logic [1:0] cod;
    logic [7:0] cafes;
  } vec_t;

  function automatic vec_t mk(int ini, int canc, int niv, int aq, int fim, int db,
                              int h, int v, int o, int p, int e, int cod, int cafes);
    vec_t t;
    t = {1'(ini), 1'(canc), 1'(niv), 1'(aq), 1'(fim), 3'(db),
         1'(h), 1'(v), 1'(o), 1'(p), 1'(e), 2'(cod), 8'(cafes)};
    return t;
  endfunction

  vec_t tab[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nv, np;
    tab[0]  = mk(1,0,1,0,0, 1, 0,0,1,0,0, 0, 0);
    tab[1]  = mk(0,0,1,1,0, 2, 1,0,1,0,0, 0, 0);
    tab[2]  = mk(0,0,0,1,0, 3, 1,1,1,0,0, 0, 0);
    tab[3]  = mk(1,0,0,0,0, 4, 1,0,1,0,0, 0, 0);
    tab[4]  = mk(0,0,0,0,1, 5, 0,0,1,1,0, 0, 1);
    tab[5]  = mk(0,0,0,0,0, 0, 0,0,0,0,0, 0, 1);
    tab[6]  = mk(1,0,0,0,0, 1, 0,0,1,0,0, 0, 1);
    tab[7]  = mk(0,0,0,0,0, 6, 0,0,0,0,1, 1, 1);
    tab[8]  = mk(1,0,0,0,1, 6, 0,0,0,0,1, 1, 1);
    tab[9]  = mk(1,1,0,0,0, 0, 0,0,0,0,0, 0, 1);
    tab[10] = mk(0,1,0,0,0, 0, 0,0,0,0,0, 0, 1);
    tab[11] = mk(1,0,1,0,0, 1, 0,0,1,0,0, 0, 1);
    tab[12] = mk(0,0,1,0,0, 2, 1,0,1,0,0, 0, 1);
    tab[13] = mk(0,1,1,1,0, 0, 0,0,0,0,0, 0, 1);

    #12;
    chk("reset_outputs", 32'(saida_dut()), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      ciclo(tab[i].ini, tab[i].canc, tab[i].niv, tab[i].aq, tab[i].fim);
      chk($sformatf("tab%0d", i), 32'(saida_dut()),
          32'({tab[i].db, tab[i].h, tab[i].v, tab[i].o, tab[i].p, tab[i].e,
               tab[i].cod, tab[i].cafes}));
    end

    // nominal brew with iniciar pulses during dispense
    aplica_reset();
    nv = 0; np = 0;
    ciclo(1, 0, 1, 0, 0);
    ciclo(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin ciclo(0, 0, 1, 0, 0); nv += liga_valvula; end
    ciclo(0, 0, 1, 1, 0); nv += liga_valvula;
    chk("nominal_valve_latency", 32'(liga_valvula), 32'd1);
    for (int i = 0; i < 9; i++) begin
      ciclo(i % 3 == 1, 0, 1, 0, 0); nv += liga_valvula; np += pronto;
    end
    ciclo(0, 0, 1, 0, 1); nv += liga_valvula; np += pronto;
    ciclo(0, 0, 1, 0, 0); nv += liga_valvula; np += pronto;
    chk("nominal_valve_pulses", 32'(nv), 32'd1);
    chk("nominal_pronto_pulses", 32'(np), 32'd1);
    chk("nominal_cafes", 32'(cafes_servidos), 32'd1);
    chk("nominal_heater_off", 32'(liga_aquecedor), 32'd0);

    // heat timeout
    ciclo(1, 0, 1, 0, 0);
    ciclo(0, 0, 1, 0, 0);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      ciclo(0, 0, 1, 0, (i % 3) == 0);
      if (db_estado == 3'd6) begin k = i; break; end
    end
    chk("heat_timeout_cycles", 32'(k), 32'(TA));
    chk("heat_timeout_code", 32'(codigo_erro), 32'd2);
    chk("heat_timeout_heater", 32'(liga_aquecedor), 32'd0);
    ciclo(0, 0, 1, 0, 1);
    ciclo(1, 0, 1, 0, 1);
    chk("erro_ignores_fim", 32'(db_estado), 32'd6);
    ciclo(0, 1, 1, 0, 0);
    chk("erro_cancel", 32'({db_estado, codigo_erro}), 32'd0);

    // valve timeout
    ciclo(1, 0, 1, 0, 0);
    ciclo(0, 0, 1, 0, 0);
    ciclo(0, 0, 1, 1, 0);
    ciclo(0, 0, 1, 0, 0);
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      ciclo(0, 1, 1, 0, 0);
      if (db_estado == 3'd6) begin k = i; break; end
    end
    chk("valve_timeout_cycles", 32'(k), 32'(TV));
    chk("valve_timeout_code", 32'(codigo_erro), 32'd3);
    ciclo(0, 1, 1, 0, 0);

    // fim_valvula on the timeout cycle wins
    ciclo(1, 0, 1, 0, 0);
    ciclo(0, 0, 1, 0, 0);
    ciclo(0, 0, 1, 1, 0);
    ciclo(0, 0, 1, 0, 0);
    for (int i = 1; i < TV; i++) ciclo(0, 0, 1, 0, 0);
    ciclo(0, 0, 1, 0, 1);
    chk("tie_state", 32'({db_estado, pronto, erro}), 32'({3'd5, 1'b1, 1'b0}));
    chk("tie_cafes", 32'(cafes_servidos), 32'd2);
    ciclo(0, 0, 1, 0, 0);

    // asynchronous reset mid-dispense
    ciclo(1, 0, 1, 0, 0);
    ciclo(0, 0, 1, 0, 0);
    ciclo(0, 0, 1, 1, 0);
    ciclo(0, 0, 1, 0, 0);
    ciclo(0, 0, 1, 0, 0);
    chk("pre_reset_heater", 32'(liga_aquecedor), 32'd1);
    @(negedge clock);
    #3 reset = 1'b0;
    #1 chk("async_reset_outputs", 32'(saida_dut()), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // counter saturation
    for (int i = 0; i < 255; i++) preparo_rapido();
    chk("cafes_255", 32'(cafes_servidos), 32'd255);
    ciclo(1, 0, 1, 0, 0);
    ciclo(0, 0, 1, 0, 0);
    ciclo(0, 0, 1, 1, 0);
    ciclo(0, 0, 1, 0, 0);
    ciclo(0, 0, 1, 0, 1);
    chk("sat_pronto", 32'(pronto), 32'd1);
    chk("sat_cafes", 32'(cafes_servidos), 32'd255);
    ciclo(0, 0, 1, 0, 0);

    // random stimulus against the model
    aplica_reset();
    for (int i = 0; i < 3000; i++) begin
      ciclo($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 29) == 0);
    end

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
